// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Runs on the PLL output clock. It synchronises the PLL `locked` flag and
//   requires it to stay high for LOCK_HOLD cycles. It then holds the core
//   reset for RESET_CYCLES cycles. Once running, it generates the CPU
//   phi1/phi2 clock-enable strobes. Any loss of lock returns the core to reset.
//
//   Optional build macro: LOCK_LOSS_COUNT_EN
//     Adds an 8-bit saturating lock_loss_count output. It counts the
//     RUN -> WAIT_LOCK transitions and is cleared only by rst.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_HOLD    = 1024,
  parameter int RESET_CYCLES = 64,
  parameter int CE_DIV       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_rst,
  output logic       ready,
  output logic       cpu_phi1_ce,
  output logic       cpu_phi2_ce
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  // One counter is shared between lock qualification and reset hold, so it
  // is sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (LOCK_HOLD > RESET_CYCLES) ? LOCK_HOLD : RESET_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int PW      = $clog2(CE_DIV);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CE_DIV - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(CE_DIV / 2);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    RESET_HOLD = 2'd2,
    RUN        = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_sync;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   cnt_next;
  logic [PW-1:0]   phase_reg;
  logic [PW-1:0]   phase_next;

  // Shift register that brings the asynchronous lock flag into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_sync = sync_reg[SYNC_STAGES-1];

  // State, shared-counter and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
      phase_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  // Next-state logic. A loss of lock always wins over a terminal count, so
  // a glitch restarts qualification from scratch.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    case (state_reg)
      WAIT_LOCK: begin
        cnt_next = '0;
        if (locked_sync) begin
          state_next = STABILIZE;
        end
      end
      STABILIZE: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = RESET_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESET_HOLD: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == RST_LAST) begin
          state_next = RUN;
          cnt_next   = '0;
          phase_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RUN: begin
        cnt_next = '0;
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          phase_next = '0;
        end else if (phase_reg == PHASE_LAST) begin
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
        phase_next = '0;
      end
    endcase
  end

  // Moore output decode from the state and phase registers only.
  always_comb begin
    sys_rst     = 1'b1;
    ready       = 1'b0;
    cpu_phi1_ce = 1'b0;
    cpu_phi2_ce = 1'b0;
    if (state_reg == RUN) begin
      sys_rst     = 1'b0;
      ready       = 1'b1;
      cpu_phi1_ce = (phase_reg == '0);
      cpu_phi2_ce = (phase_reg == PHASE_HALF);
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_cnt_reg;

  // Saturating count of lock losses that occur while the core is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_reg <= '0;
    end else if ((state_reg == RUN) && (state_next == WAIT_LOCK) &&
                 (loss_cnt_reg != 8'hFF)) begin
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
    end
  end

  assign lock_loss_count = loss_cnt_reg;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed, table-driven bench for pll_reset_sequencer with SYNC_STAGES=2,
//   LOCK_HOLD=8, RESET_CYCLES=4 and CE_DIV=4. Each vector gives the inputs
//   driven just after a rising edge. It also gives the outputs expected in
//   that same cycle, as {sys_rst, ready, cpu_phi1_ce, cpu_phi2_ce}.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst;
  logic locked;
  logic sys_rst;
  logic ready;
  logic cpu_phi1_ce;
  logic cpu_phi2_ce;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  typedef struct {
    logic       rst;
    logic       locked;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];

  pll_reset_sequencer #(
    .SYNC_STAGES (2),
    .LOCK_HOLD   (8),
    .RESET_CYCLES(4),
    .CE_DIV      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .cpu_phi1_ce(cpu_phi1_ce),
    .cpu_phi2_ce(cpu_phi2_ce)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Appends n identical single-cycle vectors to the table.
  function automatic void add(input logic r, input logic l, input logic [3:0] e, input int n);
    vec_t v;
    v.rst    = r;
    v.locked = l;
    v.exp    = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  // Drives one cycle, checks the outputs on the falling edge, and moves to just after the next rising edge.
  task automatic step(input logic r, input logic l, input logic [3:0] exp, input string name);
    logic [3:0] got;
    rst    = r;
    locked = l;
    @(negedge clk);
    got = {sys_rst, ready, cpu_phi1_ce, cpu_phi2_ce};
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: sys_rst/ready/phi1/phi2 got %b want %b", name, cyc, got, exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input logic r, input logic l, input logic [3:0] exp, input int n, input string name);
    for (int k = 0; k < n; k++) step(r, l, exp, name);
  endtask

`ifdef LOCK_LOSS_COUNT_EN
  task automatic chk_cnt(input logic [7:0] exp, input string name);
    @(negedge clk);
    n_vec++;
    if (lock_loss_count !== exp) begin
      n_miss++;
      $display("FAIL %s: lock_loss_count got %0d want %0d", name, lock_loss_count, exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
`endif

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: reset, then idle with no lock.
    add(1, 0, 4'b1000, 3);
    add(0, 0, 4'b1000, 4);
    // Clean lock: locked driven high in cycle 0 gives RUN at cycle 15.
    add(0, 1, 4'b1000, 15);
    add(0, 1, 4'b0110, 1);  // 15 phi1
    add(0, 1, 4'b0100, 1);  // 16
    add(0, 1, 4'b0101, 1);  // 17 phi2
    add(0, 1, 4'b0100, 1);  // 18
    add(0, 1, 4'b0110, 1);  // 19 phi1
    add(0, 1, 4'b0100, 1);  // 20
    add(0, 1, 4'b0101, 1);  // 21 phi2
    add(0, 1, 4'b0100, 1);  // 22
    add(0, 1, 4'b0110, 1);  // 23 phi1
    // Loss in RUN: locked low from cycle 24, back in reset at cycle 27.
    add(0, 0, 4'b0100, 1);  // 24
    add(0, 0, 4'b0101, 1);  // 25
    add(0, 0, 4'b0100, 1);  // 26
    add(0, 0, 4'b1000, 2);  // 27, 28
    // Relock in cycle 29 gives RUN at cycle 44.
    add(0, 1, 4'b1000, 15);
    add(0, 1, 4'b0110, 1);
    add(0, 1, 4'b0100, 1);

    rst    = 1'b1;
    locked = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].locked, tbl[i].exp, $sformatf("tbl[%0d]", i));

`ifdef LOCK_LOSS_COUNT_EN
    chk_cnt(8'd1, "loss_count_after_run_loss");  // RUN phase 2 this cycle
    step(1, 1, 4'b0100, "rst_from_run");         // phase 3
`else
    step(1, 1, 4'b0101, "rst_from_run");         // phase 2
`endif
    run(0, 0, 4'b1000, 3, "after_rst");
`ifdef LOCK_LOSS_COUNT_EN
    chk_cnt(8'd0, "loss_count_cleared");
`endif

    // Glitch: high 5, low 1, high again -> RUN 15 edges after second rise.
    run(0, 1, 4'b1000, 5, "glitch_first");
    step(0, 0, 4'b1000, "glitch_low");
    run(0, 1, 4'b1000, 15, "glitch_requal");
    step(0, 1, 4'b0110, "glitch_run");
    step(0, 1, 4'b0100, "glitch_run_p1");

    // Reset mid-sequence during RESET_HOLD.
    step(1, 1, 4'b0101, "rst_from_run2");
    run(0, 0, 4'b1000, 3, "idle2");
    run(0, 1, 4'b1000, 12, "mid_qualify");
    step(1, 1, 4'b1000, "mid_rst");
    run(0, 1, 4'b1000, 15, "mid_after_rst");
    step(0, 1, 4'b0110, "mid_run");
    step(0, 1, 4'b0100, "mid_run_p1");

`ifdef LOCK_LOSS_COUNT_EN
    // Saturation: repeated RUN losses.
    step(1, 0, 4'b0101, "sat_rst");
    for (int it = 0; it < 260; it++) begin
      int wait_cnt;
      rst    = 1'b0;
      locked = 1'b1;
      wait_cnt = 0;
      while (ready !== 1'b1 && wait_cnt < 40) begin
        @(posedge clk);
        #1;
        wait_cnt++;
      end
      n_vec++;
      if (ready !== 1'b1) begin
        n_miss++;
        $display("FAIL sat_ready iter %0d: ready got %b want 1", it, ready);
        break;
      end
      locked   = 1'b0;
      wait_cnt = 0;
      while (ready !== 1'b0 && wait_cnt < 10) begin
        @(posedge clk);
        #1;
        wait_cnt++;
      end
      if (ready !== 1'b0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sat_drop iter %0d: ready got %b want 0", it, ready);
        break;
      end
    end
    chk_cnt(8'd255, "loss_count_saturated");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
